raster_scanner: RTL

- Upstream stage of the snake pixel drawer. Generates the raster pixel coordinates x/y, the linear framebuffer SRAM address and the pixel write strobe for one frame per start request.
- Arbitrates for the shared framebuffer bus with the LCD readout path via a req/gnt handshake. It paces pixels so the drawer's registered data and active-low write enable meet SRAM timing.

---
 rtl/raster_scanner.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/raster_scanner.sv
// raster_scanner: per-frame raster x/y/address generator with paced pixel strobe and framebuffer bus req/gnt.
// Optional RASTER_OVERRUN_EN: counts start requests dropped while busy (otherwise overrun_cnt is tied 0).
module raster_scanner #(
    parameter int H_RES   = 320,
    parameter int V_RES   = 240,
    parameter int PIX_DIV = 4,
    parameter int ADDR_W  = 17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              bus_gnt,
    output logic              bus_req,
    output logic [8:0]        x,
    output logic [8:0]        y,
    output logic [ADDR_W-1:0] addr,
    output logic              pix_valid,
    output logic              busy,
    output logic              frame_done,
    output logic [7:0]        overrun_cnt
);

    localparam int                DIV_W   = $clog2(PIX_DIV);
    localparam logic [DIV_W-1:0]  DIV_PRE = DIV_W'(PIX_DIV - 2);
    localparam logic [8:0]        X_LAST  = 9'(H_RES - 1);
    localparam logic [8:0]        Y_LAST  = 9'(V_RES - 1);

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_SCAN, S_HOLD, S_DONE} state_t;

    state_t            r_state;
    logic [DIV_W-1:0]  r_div;
    logic [8:0]        r_x;
    logic [8:0]        r_y;
    logic [ADDR_W-1:0] r_addr;
    logic              r_bus_req;
    logic              r_pix_valid;
    logic              r_busy;
    logic              r_frame_done;
    logic              w_last;

    assign w_last = (r_x == X_LAST) && (r_y == Y_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_div        <= '0;
            r_x          <= '0;
            r_y          <= '0;
            r_addr       <= '0;
            r_bus_req    <= 1'b0;
            r_pix_valid  <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_pix_valid  <= 1'b0;
            r_frame_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state   <= S_REQ;
                        r_div     <= '0;
                        r_x       <= '0;
                        r_y       <= '0;
                        r_addr    <= '0;
                        r_bus_req <= 1'b1;
                        r_busy    <= 1'b1;
                    end
                end
                S_REQ: begin
                    if (bus_gnt) begin
                        r_state <= S_SCAN;
                        r_div   <= '0;
                    end
                end
                S_SCAN: begin
                    if (r_pix_valid && w_last) begin
                        r_state      <= S_DONE;
                        r_div        <= '0;
                        r_bus_req    <= 1'b0;
                        r_frame_done <= 1'b1;
                    end else begin
                        // A strobe coinciding with grant loss still retires its pixel.
                        if (r_pix_valid) begin
                            r_addr <= r_addr + ADDR_W'(1);
                            if (r_x == X_LAST) begin
                                r_x <= '0;
                                r_y <= r_y + 9'd1;
                            end else begin
                                r_x <= r_x + 9'd1;
                            end
                        end
                        if (!bus_gnt) begin
                            r_state <= S_HOLD;
                            r_div   <= '0;
                        end else begin
                            r_div       <= r_pix_valid ? '0 : r_div + DIV_W'(1);
                            r_pix_valid <= !r_pix_valid && (r_div == DIV_PRE);
                        end
                    end
                end
                S_HOLD: begin
                    if (bus_gnt) begin
                        r_state <= S_SCAN;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_bus_req <= 1'b0;
                    r_busy    <= 1'b0;
                end
            endcase
        end
    end

    assign bus_req    = r_bus_req;
    assign x          = r_x;
    assign y          = r_y;
    assign addr       = r_addr;
    assign pix_valid  = r_pix_valid;
    assign busy       = r_busy;
    assign frame_done = r_frame_done;

`ifdef RASTER_OVERRUN_EN
    logic [7:0] r_overrun_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overrun_cnt <= '0;
        end else if (start && r_busy && (r_overrun_cnt != 8'hFF)) begin
            r_overrun_cnt <= r_overrun_cnt + 8'd1;
        end
    end

    assign overrun_cnt = r_overrun_cnt;
`else
    assign overrun_cnt = 8'd0;
`endif

endmodule
